// File: rtl/mac_pipe_param.sv
// Parametrised three-stage multiply-accumulate: operand register, product register,
// accumulator with wrap/saturate, signed/unsigned arithmetic and a sticky overflow flag.
module mac_pipe_param #(
  parameter int IN_W   = 128,
  parameter int ACC_W  = 512,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  input  logic [IN_W-1:0]  A_in,
  input  logic [IN_W-1:0]  B_in,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  output logic             overflow
);

  localparam int PW        = 2 * IN_W;
  localparam bit IS_SIGNED = (SIGNED != 0);
  localparam bit IS_SAT    = (SAT != 0);

  generate
    if (ACC_W < PW) begin : g_param_check
      $error("mac_pipe_param: ACC_W must be >= 2*IN_W");
    end
  endgenerate

  // Handshake: a beat is taken on a rising edge when in_valid && in_ready;
  // in_ready is en, so the only backpressure is the global stall.
  assign in_ready = en;

  logic            r_s1_valid, r_s1_clr;
  logic [IN_W-1:0] r_s1_a, r_s1_b;
  logic            r_s2_valid, r_s2_clr;
  logic [PW-1:0]   r_s2_p;
  logic [ACC_W-1:0] r_acc;
  logic            r_ovf, r_out_valid;

  logic [PW-1:0]    w_a_ext, w_b_ext, w_prod;
  logic             w_p_sign, w_acc_sign, w_ovf_s, w_ovf_u, w_sum_ovf;
  logic [ACC_W:0]   w_p_ext, w_acc_ext, w_sum;
  logic [ACC_W-1:0] w_sat_val, w_acc_nxt;
  logic             w_ovf_nxt;

  // Extending both operands to the product width makes one unsigned multiply
  // give the correct low PW bits for either signedness.
  assign w_a_ext = {{IN_W{IS_SIGNED & r_s1_a[IN_W-1]}}, r_s1_a};
  assign w_b_ext = {{IN_W{IS_SIGNED & r_s1_b[IN_W-1]}}, r_s1_b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_p_sign   = IS_SIGNED & r_s2_p[PW-1];
  assign w_p_ext    = {{(ACC_W + 1 - PW){w_p_sign}}, r_s2_p};
  assign w_acc_sign = IS_SIGNED & r_acc[ACC_W-1];
  assign w_acc_ext  = {w_acc_sign, r_acc};
  assign w_sum      = w_acc_ext + w_p_ext;

  assign w_ovf_u   = w_sum[ACC_W];
  assign w_ovf_s   = (r_acc[ACC_W-1] == w_p_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_sum_ovf = IS_SIGNED ? w_ovf_s : w_ovf_u;

  // Signed saturation direction follows the common operand sign.
  always_comb begin
    w_sat_val = '1;
    if (IS_SIGNED) begin
      w_sat_val = r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    w_acc_nxt = r_acc;
    w_ovf_nxt = r_ovf;
    if (r_s2_valid) begin
      if (r_s2_clr) begin
        w_acc_nxt = w_p_ext[ACC_W-1:0];
        w_ovf_nxt = 1'b0;
      end else if (w_sum_ovf) begin
        w_acc_nxt = IS_SAT ? w_sat_val : w_sum[ACC_W-1:0];
        w_ovf_nxt = 1'b1;
      end else begin
        w_acc_nxt = w_sum[ACC_W-1:0];
      end
    end else if (r_s2_clr) begin
      w_acc_nxt = '0;
      w_ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_clr    <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_clr    <= 1'b0;
      r_s2_p      <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (en) begin
      r_s1_valid  <= in_valid;
      r_s1_clr    <= clr;
      if (in_valid) begin
        r_s1_a <= A_in;
        r_s1_b <= B_in;
      end
      r_s2_valid  <= r_s1_valid;
      r_s2_clr    <= r_s1_clr;
      r_s2_p      <= w_prod;
      r_acc       <= w_acc_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= r_s2_valid;
    end else begin
      // Stall: everything holds except the result strobe, which drops.
      r_out_valid <= 1'b0;
    end
  end

  assign acc_out   = r_acc;
  assign overflow  = r_ovf;
  assign out_valid = r_out_valid;

endmodule

// File: doc/mac_pipe_param.md
Name: mac_pipe_param

Overview:
Parametrised, pipelined multiply-accumulate unit. It succeeds the fixed 128x128 -> 512-bit MAC and adds:
- configurable widths
- signed/unsigned arithmetic
- wrap or saturate accumulation
- a valid/ready input handshake
- a per-sample accumulator clear
- a sticky overflow flag

It sits in the datapath compute array, fed by an operand streamer, and its result is read by the host interface.

Parameters:
IN_W, 128, width of each operand A_in/B_in
ACC_W, 512, accumulator width; must be >= 2*IN_W (elaboration error otherwise)
SIGNED, 0, 0 = unsigned operands/accumulator, 1 = two's complement
SAT, 0, 0 = wrap on overflow, 1 = saturate to max/min representable value

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  global advance; 0 freezes every pipeline stage
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept; equals en
clr  input  1  sideband with the sample: start a new accumulation
A_in  input  IN_W  operand A
B_in  input  IN_W  operand B
acc_out  output  ACC_W  accumulator value
out_valid  output  1  one-cycle pulse when acc_out updated by a valid sample
overflow  output  1  sticky overflow since last clear

Behaviour:
- Reset (rst_n=0, async): all stage registers, acc_out, out_valid and overflow are 0. Deassertion is sampled synchronously by the first edge.
- Accept: a beat is accepted on a rising edge when in_valid=1 and in_ready=1. in_ready is combinationally equal to en; there is no other backpressure.
- Pipeline, with each stage advancing only when en=1:
  - S1 registers {valid, clr, A, B}.
  - S2 registers product P = A*B, 2*IN_W bits, signed if SIGNED=1, plus the valid and clr flags.
  - S3 is the accumulator.
- Latency: acc_out and out_valid update on the 3rd rising edge, counting the accepting edge as the 1st, provided en stays 1. With continuous input there is 1 result per cycle.
- en=0: every register, including acc_out and overflow, holds. out_valid is forced 0 during the stall and re-asserts when the held valid beat completes.
- Width extension: P is sign- or zero-extended to ACC_W+1 bits before the add.
- S3 update when S2.valid=1 and en=1:
  - clr=1: acc <= ext(P), overflow <= 0.
  - clr=0: sum = acc + ext(P).
- Overflow detect:
  - Unsigned: carry out of bit ACC_W-1.
  - Signed: both operands have the same sign and the result sign differs.
- On overflow:
  - SAT=0: acc <= sum[ACC_W-1:0].
  - SAT=1: acc <= all-ones (unsigned); or max positive / min negative, following the sign of the operands (signed).
  - In both modes overflow <= 1 (sticky).
- clr beat without valid (in_valid=0, clr=1, en=1): the bubble carries clr. At S3, acc <= 0, overflow <= 0, out_valid stays 0.
- Bubble with clr=0: S3 holds and out_valid=0.
- Operands are ignored when in_valid=0.
- Reset mid-operation flushes all in-flight beats; no out_valid follows for them.

Test Plan:
- Default params, en=1 from cycle 1, A=3, B=7, in_valid=1 for 4 beats, clr=1 on the first beat -> acc_out = 21, 42, 63, 84 on edges 3..6, out_valid high on those 4 edges, overflow=0.
- Same stream with en=0 for 2 cycles after the 2nd accept -> acc_out holds at its current value, out_valid=0 during the stall, final value 84 with total delay +2 cycles.
- IN_W=4, ACC_W=8, SIGNED=0: A=B=15 twice, then A=B=15 with clr=1.
  - SAT=0 -> acc 225, then 194 with overflow=1, then 225 with overflow=0.
  - SAT=1 -> 225, then 255 with overflow=1.
- IN_W=4, ACC_W=8, SIGNED=1, SAT=1: A=B=-8 twice (first beat clr=1) -> acc 64, then 127 with overflow=1. Then a clr bubble -> acc 0, overflow 0, no out_valid.
- Assert rst_n=0 asynchronously, mid-clock, while 2 beats are in flight -> acc_out, out_valid and overflow go to 0 immediately. After release, no stale out_valid appears; a new clr beat A=2, B=5 yields 10.
